// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder and the control unit's
// load/store decode: access size codes, responder states, fault rule.
package mem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  localparam int LAT_CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_MERGE,
    ST_WR,
    ST_RESP,
    ST_FLT
  } mem_state_t;

  // A request is rejected for conflicting commands, the reserved size code,
  // or an address not aligned to the access size.
  function automatic logic req_fault(input logic       rd,
                                     input logic       wr,
                                     input logic [1:0] sz,
                                     input logic [1:0] lo);
    return (rd && wr) ||
           (sz == 2'b11) ||
           ((sz == SIZE_HALF) && lo[0]) ||
           ((sz == SIZE_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane logic: extracts and extends sub-word loads, and merges
// sub-word store data into a fetched word (little-endian lanes).
module byte_lane_unit
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        unsignedn,
  input  logic [1:0]  offset,
  input  logic [31:0] fetched,
  input  logic [31:0] write_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = fetched[7:0];
    case (offset)
      2'd1:    byte_lane = fetched[15:8];
      2'd2:    byte_lane = fetched[23:16];
      2'd3:    byte_lane = fetched[31:24];
      default: byte_lane = fetched[7:0];
    endcase
    half_lane = offset[1] ? fetched[31:16] : fetched[15:0];

    load_data = fetched;
    merged    = write_data;
    case (size)
      SIZE_HALF: begin
        load_data = unsignedn ? {16'h0000, half_lane}
                              : {{16{half_lane[15]}}, half_lane};
        merged    = offset[1] ? {write_data[15:0], fetched[15:0]}
                              : {fetched[31:16], write_data[15:0]};
      end
      SIZE_BYTE: begin
        load_data = unsignedn ? {24'h000000, byte_lane}
                              : {{24{byte_lane[7]}}, byte_lane};
        merged    = fetched;
        case (offset)
          2'd1:    merged[15:8]  = write_data[7:0];
          2'd2:    merged[23:16] = write_data[7:0];
          2'd3:    merged[31:24] = write_data[7:0];
          default: merged[7:0]   = write_data[7:0];
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: fixed-latency word/half/byte loads, read-modify-write
// sub-word stores, and single-cycle fault completion for illegal requests.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_W  = 8,
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        unsignedn,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        busy,
  output logic        mem_fault
);

  localparam logic [LAT_CNT_W-1:0] LAST_CNT = LAT_CNT_W'(READ_LAT - 1);

  mem_state_t           state;
  logic [LAT_CNT_W-1:0] lat_cnt;
  logic                 is_write_q;

  logic [DEPTH_W-1:0]   idx_q;
  logic [1:0]           off_q;
  logic [1:0]           size_q;
  logic                 uns_q;
  logic [31:0]          wdata_q;

  logic [31:0]          mem [0:(1<<DEPTH_W)-1];
  logic [31:0]          fetched;
  logic [31:0]          load_data;
  logic [31:0]          merged;
  logic                 req;
  logic                 accept;
  logic                 unused_addr_hi;

  assign req            = mem_read || mem_write;
  // RESP is the completion cycle; busy is already low, so it accepts like IDLE.
  assign accept         = ((state == ST_IDLE) || (state == ST_RESP)) && req;
  assign fetched        = mem[idx_q];
  assign unused_addr_hi = ^address[31:DEPTH_W+2];

  byte_lane_unit u_lane (
    .size       (size_q),
    .unsignedn  (uns_q),
    .offset     (off_q),
    .fetched    (fetched),
    .write_data (wdata_q),
    .load_data  (load_data),
    .merged     (merged)
  );

  // Request capture; the merge step overwrites the store word in place.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= address[DEPTH_W+1:2];
      off_q   <= address[1:0];
      size_q  <= size;
      uns_q   <= unsignedn;
      wdata_q <= write_data;
    end else if (state == ST_MERGE) begin
      wdata_q <= merged;
    end
  end

  // Array write only in WR, so an abandoned store never reaches memory.
  always_ff @(posedge clk) begin
    if (state == ST_WR) begin
      mem[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      is_write_q <= 1'b0;
      read_data  <= 32'h0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      mem_fault  <= 1'b0;
    end else begin
      ready     <= 1'b0;
      mem_fault <= 1'b0;
      case (state)
        ST_IDLE, ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (req) begin
            busy       <= 1'b1;
            is_write_q <= mem_write;
            lat_cnt    <= '0;
            if (req_fault(mem_read, mem_write, size, address[1:0])) begin
              state <= ST_FLT;
            end else if (mem_write && (size == SIZE_WORD)) begin
              state <= ST_WR;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (lat_cnt == LAST_CNT) begin
            lat_cnt <= '0;
            if (is_write_q) begin
              state <= ST_MERGE;
            end else begin
              state     <= ST_RESP;
              ready     <= 1'b1;
              busy      <= 1'b0;
              read_data <= load_data;
            end
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        ST_MERGE: state <= ST_WR;
        ST_WR: begin
          state <= ST_RESP;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
        ST_FLT: begin
          state     <= ST_IDLE;
          ready     <= 1'b1;
          mem_fault <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and randomized checks of data_mem_responder against a byte-level
// reference model of the memory.
module tb_data_mem_responder;

  localparam int DEPTH_W  = 8;
  localparam int READ_LAT = 2;
  localparam int NBYTES   = 4 << DEPTH_W;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        unsignedn = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        ready;
  logic        busy;
  logic        mem_fault;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mb [0:NBYTES-1];
  logic [31:0] last_rd = 32'h0;
  logic [31:0] obs_rd;

  data_mem_responder #(.DEPTH_W(DEPTH_W), .READ_LAT(READ_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .size       (size),
    .unsignedn  (unsignedn),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .busy       (busy),
    .mem_fault  (mem_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes_of(input logic [1:0] sz);
    return (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic un, input logic [31:0] a);
    int     base = int'(a) & (NBYTES - 1);
    int     n    = nbytes_of(sz);
    longint v    = 0;
    for (int i = 0; i < n; i++) v += longint'(mb[(base + i) % NBYTES]) << (8 * i);
    if (!un && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  function automatic void m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int base = int'(a) & (NBYTES - 1);
    for (int i = 0; i < nbytes_of(sz); i++) mb[(base + i) % NBYTES] = 8'(wd >> (8 * i));
  endfunction

  function automatic logic m_fault(input logic rd, input logic wr, input logic [1:0] sz, input logic [31:0] a);
    if (rd && wr) return 1'b1;
    if (sz == 2'b11) return 1'b1;
    return (int'(a) % nbytes_of(sz)) != 0;
  endfunction

  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    mem_read = rd; mem_write = wr; size = sz; unsignedn = un; address = a; write_data = wd;
    @(posedge clk);
    #1;
    mem_read = 1'b0; mem_write = 1'b0;
    size = 2'($urandom); unsignedn = 1'($urandom); address = $urandom; write_data = $urandom;
  endtask

  task automatic txn(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                     input logic un, input logic [31:0] a, input logic [31:0] wd);
    logic        flt;
    int          exp_lat;
    int          got;
    logic        busy0;
    logic [31:0] exp_rd;
    flt     = m_fault(rd, wr, sz, a);
    exp_lat = flt ? 1 : rd ? READ_LAT : (sz == 2'b00) ? 1 : READ_LAT + 2;
    exp_rd  = (!flt && rd) ? m_load(sz, un, a) : last_rd;
    got     = -1;
    busy0   = 1'b0;
    issue(rd, wr, sz, un, a, wd);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) busy0 = busy;
      if (ready) begin
        got = k;
        break;
      end
    end
    chk({tag, "_busy_start"}, 32'(busy0), 32'd1);
    chk({tag, "_latency"}, 32'(got), 32'(exp_lat));
    if (got >= 0) begin
      obs_rd = read_data;
      chk({tag, "_fault"}, 32'(mem_fault), 32'(flt));
      chk({tag, "_busy_at_ready"}, 32'(busy), 32'd0);
      chk({tag, "_read_data"}, read_data, exp_rd);
      @(negedge clk);
      chk({tag, "_ready_pulse"}, 32'(ready), 32'd0);
    end
    last_rd = exp_rd;
    if (!flt && wr) m_store(sz, a, wd);
  endtask

  initial begin
    int pulses;
    repeat (3) @(negedge clk);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fault", 32'(mem_fault), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) txn("fill", 1'b0, 1'b1, 2'b00, 1'b0, 32'(i * 4), $urandom);

    // Reset in the second cycle of a read abandons it.
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midrd_ready", 32'(ready), 32'd0);
    chk("midrd_busy", 32'(busy), 32'd0);
    chk("midrd_read_data", read_data, 32'h0);
    @(negedge clk) reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    chk("midrd_no_ready", 32'(pulses), 32'd0);
    last_rd = 32'h0;

    // Reset during a sub-word store leaves the array untouched.
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h15, 32'h000000AA);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    txn("midwr_check", 1'b1, 1'b0, 2'b00, 1'b0, 32'h14, 32'h0);

    txn("st_word", 1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF);
    txn("ld_word", 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    chk("ld_word_const", obs_rd, 32'hDEADBEEF);
    txn("ld_byte_s", 1'b1, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    chk("ld_byte_s_const", obs_rd, 32'hFFFFFFDE);
    txn("ld_byte_u", 1'b1, 1'b0, 2'b10, 1'b1, 32'h13, 32'h0);
    chk("ld_byte_u_const", obs_rd, 32'h000000DE);
    txn("ld_half_s", 1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    chk("ld_half_s_const", obs_rd, 32'hFFFFBEEF);
    txn("st_byte", 1'b0, 1'b1, 2'b10, 1'b0, 32'h11, 32'h00000055);
    txn("ld_merged", 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    chk("ld_merged_const", obs_rd, 32'hDEAD55EF);
    txn("flt_half", 1'b1, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
    txn("flt_word_st", 1'b0, 1'b1, 2'b00, 1'b0, 32'h22, 32'h01234567);
    txn("after_flt_ld", 1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
    txn("flt_both", 1'b1, 1'b1, 2'b00, 1'b0, 32'h20, 32'h0);
    txn("flt_size3", 1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
    txn("wrap_st", 1'b0, 1'b1, 2'b00, 1'b0, 32'h400, 32'hCAFEF00D);
    txn("wrap_ld", 1'b1, 1'b0, 2'b00, 1'b0, 32'h000, 32'h0);
    chk("wrap_ld_const", obs_rd, 32'hCAFEF00D);

    // A store presented while a read is in flight is dropped.
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    mem_write = 1'b1; size = 2'b00; address = 32'h10; write_data = 32'h12345678;
    @(posedge clk);
    #1 mem_write = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ready) begin
        pulses++;
        chk("drop_read_data", read_data, m_load(2'b00, 1'b0, 32'h10));
      end
    end
    chk("drop_one_pulse", 32'(pulses), 32'd1);
    last_rd = m_load(2'b00, 1'b0, 32'h10);
    txn("drop_unchanged", 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);

    for (int n = 0; n < 80; n++) begin
      logic        rd;
      logic        wr;
      int          pick;
      logic [31:0] a;
      pick = int'($urandom_range(0, 19));
      rd   = (pick < 9) || (pick == 19);
      wr   = (pick >= 9);
      a    = ($urandom & ~32'(NBYTES - 1)) | 32'($urandom_range(0, 63));
      txn("rand", rd, wr, 2'($urandom), 1'($urandom), a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
